mdio_peripheral: RTL and testbench
==================================

# mdio_peripheral

MDIO management target that sits directly downstream of the MDIO controller. It recovers 32-bit management frames from `mdc`/`mdio_out`/`mdio_oe` and services writes into a 32 x 16 register file. For read frames it returns register contents on `mdio_in`, which the controller samples and assembles into `rd_data`.

## Interface
Parameters:
- `PHY_ADDR`, default 5'h0A: PHY address this target answers to.
- `PHY_ID`, default 32'h0141_0CC2: identifier returned in registers 2 and 3 when `MDIO_PERIPH_ID_EN` is defined.

Ports:
- `clk`  in  1  system clock; `mdc` is generated synchronously from this clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mdc`  in  1  management clock from the controller.
- `mdio_out`  in  1  serial data from the controller, MSB first.
- `mdio_oe`  in  1  controller drive enable; 1 = `mdio_out` valid.
- `mdio_in`  out  1  serial read data returned to the controller.
- `busy`  out  1  high from the first header bit until the frame ends.
- `wr_pulse`  out  1  one-`clk` strobe when a register write commits.
- `wr_addr`  out  5  register address of the committed write.
- `wr_data`  out  16  data of the committed write.
- `frame_err`  out  1  one-`clk` strobe when a frame is aborted or rejected.

## Operation
- Frame, MSB first: ST[31:30], OP[29:28], PHYAD[27:23], REGAD[22:18], TA[17:16], DATA[15:0].
- A `mdc` rising edge is detected when registered `mdc_d`=0 and `mdc`=1. A falling edge is detected when `mdc_d`=1 and `mdc`=0.
- FSM states: IDLE, HEADER, WRITE, READ, SKIP.
- IDLE: on a rising edge with `mdio_oe`=1, shift in `mdio_out`, set bit count to 1, and go to HEADER.
- HEADER: shift one bit on each rising edge. When 16 bits have been shifted, decode the header:
  - ST=01, OP=01, PHYAD=`PHY_ADDR` -> WRITE.
  - ST=01, OP=10, PHYAD=`PHY_ADDR` -> READ; latch `regs[REGAD]` into the read shifter.
  - PHYAD mismatch with an otherwise valid header -> SKIP, with no `frame_err`.
  - Any other ST/OP -> SKIP and pulse `frame_err`.
- TA bits are don't-care.
- WRITE: shift 16 data bits. After the 16th bit, write `regs[REGAD]`, pulse `wr_pulse`, drive `wr_addr`/`wr_data`, and return to IDLE.
- READ: on each `mdc` falling edge, drive the next data bit on `mdio_in`, starting with bit 15. After the 16th bit has been held through its rising edge, clear `mdio_in` to 0 and return to IDLE. `mdio_oe` is ignored in this state.
- SKIP: count 16 rising edges, then return to IDLE. No register access and `mdio_in` stays 0.
- Abort: a rising edge with `mdio_oe`=0 in HEADER or WRITE returns the FSM to IDLE, discards the frame, and pulses `frame_err`.
- Registers reset to 16'h0000; all 32 addresses are read/write.

## Timing
- Reset values: `mdio_in`=0, `busy`=0, `wr_pulse`=0, `wr_addr`=0, `wr_data`=0, `frame_err`=0, FSM=IDLE, register file all zero.
- `mdio_out` is sampled in the same `clk` cycle the rising edge is detected, which is 1 `clk` after `mdc` rises.
- `wr_pulse`, `wr_addr`/`wr_data` and the register update all occur 1 `clk` after the 32nd sampled bit.
- `mdio_in` is registered and changes 1 `clk` after the detected falling edge, so it is stable before the next rising edge.
- `mdc` requirements: high ≥2 `clk` and low ≥2 `clk`.
- A write and a read of the same register in back-to-back frames return the new value.
- `reset` asserted mid-frame forces IDLE immediately and clears `mdio_in`; the partial frame has no effect.

## Configuration
- `MDIO_PERIPH_ID_EN` defined:
  - Registers 2 and 3 are read-only.
  - Reads of register 2 return `PHY_ID[31:16]`; reads of register 3 return `PHY_ID[15:0]`.
  - Writes to them still pulse `wr_pulse` but leave storage unchanged.
- `MDIO_PERIPH_ID_EN` undefined: registers 2 and 3 are ordinary read/write registers that reset to 0.

## Test plan
- Write frame 32'h5555_5555 -> `wr_pulse` once, `wr_addr`=5'h15, `wr_data`=16'h5555, `regs[21]`=16'h5555.
- Read frame 32'h6555_7777 after that write -> `mdio_in` serialises 0101010101010101 MSB first, then returns to 0; the controller's `rd_data`=16'h5555.
- Write with PHYAD=5'h03 (32'h5195_1234) -> no `wr_pulse`, no `frame_err`, `busy` high for 32 `mdc` cycles.
- `mdio_oe` dropped after 20 bits of a write -> `frame_err` pulse, FSM IDLE, target register unchanged.
- `reset` asserted during bit 8 of a read -> `mdio_in`=0 and `busy`=0 immediately; the next write frame is accepted normally.
- With `MDIO_PERIPH_ID_EN`, write 16'hFFFF to reg 2 then read it -> returns 16'h0141.

Source files
------------

// File: rtl/mdio_peripheral.sv
// mdio_peripheral: MDIO management target with a 32 x 16 register file.
// Recovers 32-bit frames (ST, OP, PHYAD, REGAD, TA, DATA; MSB first) from
// mdc/mdio_out/mdio_oe, commits writes and serialises read data on mdio_in.
// Build option: define MDIO_PERIPH_ID_EN to make registers 2 and 3 read-only
// identifier registers returning PHY_ID[31:16] and PHY_ID[15:0].
//
// Handshake: the controller qualifies every mdio_out bit with mdio_oe on the
// mdc rising edge; wr_pulse and frame_err are single-clk strobes with no
// back-pressure, and wr_addr/wr_data hold their value until the next commit.
module mdio_peripheral #(
   parameter logic [4:0]  PHY_ADDR = 5'h0A,
   parameter logic [31:0] PHY_ID   = 32'h0141_0CC2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdc,
   input  logic        mdio_out,
   input  logic        mdio_oe,
   output logic        mdio_in,
   output logic        busy,
   output logic        wr_pulse,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_err
);

`ifdef MDIO_PERIPH_ID_EN
   localparam bit ID_EN = 1'b1;
`else
   localparam bit ID_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, HEADER, WRITE, READ, SKIP} state_t;

   // FSM state is kept as a named signal so checkers can bind to it.
   state_t       state;
   state_t       state_next;

   logic         mdc_d;
   logic         rise;
   logic         fall;
   logic [15:0]  shift_q;
   logic [15:0]  hdr_next;
   logic [3:0]   bit_cnt;
   logic         last_bit;
   logic [4:0]   regad_q;
   logic [15:0]  rd_shift;
   logic [15:0]  rd_word;
   logic [15:0]  regs [32];

   logic [1:0]   hdr_st;
   logic [1:0]   hdr_op;
   logic [4:0]   hdr_phy;
   logic [4:0]   hdr_reg;
   logic         hdr_ok;
   logic         phy_match;

   logic         start;
   logic         abort;
   logic         hdr_done;
   logic         hdr_reject;
   logic         read_start;
   logic         commit;
   logic         read_end;
   logic         reg_writable;

   assign rise     = ~mdc_d & mdc;
   assign fall     = mdc_d & ~mdc;
   // Word as it will look once the current mdio_out bit is shifted in.
   assign hdr_next = {shift_q[14:0], mdio_out};
   assign last_bit = (bit_cnt == 4'd15);

   assign hdr_st    = hdr_next[15:14];
   assign hdr_op    = hdr_next[13:12];
   assign hdr_phy   = hdr_next[11:7];
   assign hdr_reg   = hdr_next[6:2];
   assign hdr_ok    = (hdr_st == 2'b01) && ((hdr_op == 2'b01) || (hdr_op == 2'b10));
   assign phy_match = (hdr_phy == PHY_ADDR);

   // Identifier registers are not backed by storage when the ID option is on.
   assign reg_writable = !(ID_EN && ((regad_q == 5'd2) || (regad_q == 5'd3)));

   // Read-data source for the register addressed by the header being decoded.
   always_comb begin
      rd_word = regs[hdr_reg];
      if (ID_EN && (hdr_reg == 5'd2)) rd_word = PHY_ID[31:16];
      if (ID_EN && (hdr_reg == 5'd3)) rd_word = PHY_ID[15:0];
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode; every transition is qualified by a detected mdc rise.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (start) state_next = HEADER;
         HEADER: begin
            if (abort) state_next = IDLE;
            else if (hdr_done) begin
               if (!hdr_ok || !phy_match) state_next = SKIP;
               else if (hdr_op == 2'b01)  state_next = WRITE;
               else                       state_next = READ;
            end
         end
         WRITE:  if (abort || commit) state_next = IDLE;
         READ:   if (read_end) state_next = IDLE;
         SKIP:   if (rise && last_bit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs and per-edge event qualifiers.
   always_comb begin
      busy       = (state != IDLE);
      start      = (state == IDLE) && rise && mdio_oe;
      abort      = rise && !mdio_oe && ((state == HEADER) || (state == WRITE));
      hdr_done   = (state == HEADER) && rise && mdio_oe && last_bit;
      hdr_reject = hdr_done && !hdr_ok;
      read_start = hdr_done && hdr_ok && phy_match && (hdr_op == 2'b10);
      commit     = (state == WRITE) && rise && mdio_oe && last_bit;
      read_end   = (state == READ) && rise && last_bit;
   end

   // mdc history, bit counter and serial input shifter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mdc_d   <= 1'b0;
         bit_cnt <= 4'd0;
         shift_q <= 16'h0000;
         regad_q <= 5'd0;
      end else begin
         mdc_d <= mdc;
         if (start)                          bit_cnt <= 4'd1;
         else if (abort)                     bit_cnt <= 4'd0;
         else if (rise && (state != IDLE))   bit_cnt <= bit_cnt + 4'd1;
         if (start)
            shift_q <= {15'h0000, mdio_out};
         else if (rise && mdio_oe && ((state == HEADER) || (state == WRITE)))
            shift_q <= hdr_next;
         if (hdr_done) regad_q <= hdr_reg;
      end
   end

   // Read shifter: loaded at header decode, one bit out per mdc falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_shift <= 16'h0000;
         mdio_in  <= 1'b0;
      end else begin
         if (read_start)
            rd_shift <= rd_word;
         else if ((state == READ) && fall)
            rd_shift <= {rd_shift[14:0], 1'b0};
         if ((state == READ) && fall)
            mdio_in <= rd_shift[15];
         else if ((state != READ) || read_end)
            mdio_in <= 1'b0;
      end
   end

   // Write-commit and error strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_pulse  <= 1'b0;
         wr_addr   <= 5'd0;
         wr_data   <= 16'h0000;
         frame_err <= 1'b0;
      end else begin
         wr_pulse  <= commit;
         frame_err <= abort || hdr_reject;
         if (commit) begin
            wr_addr <= regad_q;
            wr_data <= hdr_next;
         end
      end
   end

   // Register file storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 16'h0000;
      end else if (commit && reg_writable) begin
         regs[regad_q] <= hdr_next;
      end
   end

endmodule

// File: tb/tb_mdio_peripheral.sv
// Testbench for mdio_peripheral: table of whole frames with hand-computed
// results, plus a mid-read reset sequence.
module tb_mdio_peripheral;

   logic        clk;
   logic        reset;
   logic        mdc;
   logic        mdio_out;
   logic        mdio_oe;
   logic        mdio_in;
   logic        busy;
   logic        wr_pulse;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;
   int err_cnt  = 0;
   int busy_cnt = 0;

`ifdef MDIO_PERIPH_ID_EN
   localparam logic [15:0] EXP_R2 = 16'h0141;
   localparam logic [15:0] EXP_R3 = 16'h0CC2;
`else
   localparam logic [15:0] EXP_R2 = 16'hFFFF;
   localparam logic [15:0] EXP_R3 = 16'h0000;
`endif

   mdio_peripheral dut (
      .clk       (clk),
      .reset     (reset),
      .mdc       (mdc),
      .mdio_out  (mdio_out),
      .mdio_oe   (mdio_oe),
      .mdio_in   (mdio_in),
      .busy      (busy),
      .wr_pulse  (wr_pulse),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .frame_err (frame_err)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Strobe and busy-cycle counters sampled away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_pulse)  wr_cnt   <= wr_cnt + 1;
         if (frame_err) err_cnt  <= err_cnt + 1;
         if (busy)      busy_cnt <= busy_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One mdc period of 6 clk: low 3, high 3. mdio_in is sampled late in the
   // low phase, i.e. just before the rising edge the controller samples on.
   task automatic mdc_bit(input logic b, input logic oe, output logic s);
      @(negedge clk);
      mdc = 1'b0; mdio_out = b; mdio_oe = oe;
      repeat (2) @(negedge clk);
      s = mdio_in;
      @(negedge clk);
      mdc = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] frame, input int oe_bits, input int nbits,
                             output logic [15:0] rd);
      logic s;
      rd = 16'h0000;
      for (int i = 0; i < nbits; i++) begin
         mdc_bit(frame[31-i], (i < oe_bits), s);
         if (i >= 16) rd = {rd[14:0], s};
      end
   endtask

   task automatic idle_gap();
      @(negedge clk);
      mdc = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] frame;
      int          oe_bits;
      int          exp_wr;
      logic [4:0]  exp_addr;
      logic [15:0] exp_data;
      int          exp_err;
      int          exp_busy;
      logic [15:0] exp_rd;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic run_frame(input string tag, input vec_t v);
      int wr0, er0, bz0;
      logic [15:0] rd;
      wr0 = wr_cnt; er0 = err_cnt; bz0 = busy_cnt;
      send_frame(v.frame, v.oe_bits, 32, rd);
      idle_gap();
      check({tag, "_wr_pulses"}, wr_cnt - wr0, v.exp_wr);
      check({tag, "_frame_err"}, err_cnt - er0, v.exp_err);
      check({tag, "_busy_clks"}, busy_cnt - bz0, v.exp_busy);
      check({tag, "_rd_data"}, {16'h0, rd}, {16'h0, v.exp_rd});
      check({tag, "_idle"}, {30'h0, busy, mdio_in}, 32'h0);
      if (v.exp_wr != 0) begin
         check({tag, "_wr_addr"}, {27'h0, wr_addr}, {27'h0, v.exp_addr});
         check({tag, "_wr_data"}, {16'h0, wr_data}, {16'h0, v.exp_data});
      end
   endtask

   initial begin
      logic [15:0] rd;
      vec_t        v;

      //          frame          oe  wr addr   data      err busy rd
      vecs[0]  = '{32'h5555_5555, 32, 1, 5'h15, 16'h5555, 0, 186, 16'h0000}; // write reg 21
      vecs[1]  = '{32'h6555_7777, 16, 0, 5'h00, 16'h0000, 0, 186, 16'h5555}; // read reg 21
      vecs[2]  = '{32'h5195_1234, 32, 0, 5'h00, 16'h0000, 0, 186, 16'h0000}; // other PHY
      vecs[3]  = '{32'h1555_5555, 32, 0, 5'h00, 16'h0000, 1, 186, 16'h0000}; // bad ST
      vecs[4]  = '{32'h7555_5555, 32, 0, 5'h00, 16'h0000, 1, 186, 16'h0000}; // bad OP
      vecs[5]  = '{32'h550A_FFFF, 32, 1, 5'h02, 16'hFFFF, 0, 186, 16'h0000}; // write reg 2
      vecs[6]  = '{32'h650A_0000, 16, 0, 5'h00, 16'h0000, 0, 186, EXP_R2};   // read reg 2
      vecs[7]  = '{32'h650E_0000, 16, 0, 5'h00, 16'h0000, 0, 186, EXP_R3};   // read reg 3
      vecs[8]  = '{32'h5502_A5C3, 32, 1, 5'h00, 16'hA5C3, 0, 186, 16'h0000}; // write reg 0
      vecs[9]  = '{32'h6502_0000, 16, 0, 5'h00, 16'h0000, 0, 186, 16'hA5C3}; // read reg 0
      vecs[10] = '{32'h557E_0001, 32, 1, 5'h1F, 16'h0001, 0, 186, 16'h0000}; // write reg 31
      vecs[11] = '{32'h657E_0000, 16, 0, 5'h00, 16'h0000, 0, 186, 16'h0001}; // read reg 31
      vecs[12] = '{32'h6506_0000, 16, 0, 5'h00, 16'h0000, 0, 186, 16'h0000}; // read reg 1
      vecs[13] = '{32'h5555_5555,  8, 0, 5'h00, 16'h0000, 1,  48, 16'h0000}; // abort in header
      vecs[14] = '{32'h5555_1234, 20, 0, 5'h00, 16'h0000, 1, 120, 16'h0000}; // abort in write
      vecs[15] = '{32'h6555_0000, 16, 0, 5'h00, 16'h0000, 0, 186, 16'h5555}; // reg 21 unchanged

      // Reset block.
      reset = 1'b1; mdc = 1'b0; mdio_out = 1'b0; mdio_oe = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mdio_in",   {31'h0, mdio_in},   32'h0);
      check("rst_busy",      {31'h0, busy},      32'h0);
      check("rst_wr_pulse",  {31'h0, wr_pulse},  32'h0);
      check("rst_wr_addr",   {27'h0, wr_addr},   32'h0);
      check("rst_wr_data",   {16'h0, wr_data},   32'h0);
      check("rst_frame_err", {31'h0, frame_err}, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < NV; i++) run_frame($sformatf("v%0d", i), vecs[i]);

      // Reset while data bit 8 of a read of reg 0 (A5C3) is on mdio_in.
      send_frame(32'h6502_0000, 16, 24, rd);
      check("mid_read_mdio_in", {31'h0, mdio_in}, 32'h1);
      check("mid_read_busy",    {31'h0, busy},    32'h1);
      #2;
      reset = 1'b1; mdc = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b0;
      #1;
      check("reset_mdio_in", {31'h0, mdio_in}, 32'h0);
      check("reset_busy",    {31'h0, busy},    32'h0);
      check("reset_wr_out",  {11'h0, wr_addr, wr_data}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      v = '{32'h5555_5555, 32, 1, 5'h15, 16'h5555, 0, 186, 16'h0000};
      run_frame("post_rst_write", v);
      v = '{32'h6555_0000, 16, 0, 5'h00, 16'h0000, 0, 186, 16'h5555};
      run_frame("post_rst_read21", v);
      v = '{32'h6502_0000, 16, 0, 5'h00, 16'h0000, 0, 186, 16'h0000};
      run_frame("post_rst_read0", v);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
